fetch_response_merge: RTL

//  Consumer stage of the fetch-attributes FIFO. Pairs each instruction-memory response with the

---
 rtl/fetch_response_merge_pkg.sv | 23 ++
 rtl/fetch_response_merge_output_buffer.sv | 78 +++++++
 rtl/fetch_response_merge.sv | 101 ++++++++++
 3 files changed

// File: rtl/fetch_response_merge_pkg.sv
// Shared types for the fetch response merge stage: the attributes entry pushed by fetch
// alongside each memory request, and the merged instruction handed to decode.
package fetch_response_merge_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            predicted_taken;
        logic            fault;
    } fetch_attr_t;

    typedef struct packed {
        fetch_attr_t     attr;
        logic [XLEN-1:0] instr;
    } fetch_instr_t;

    // Width of a counter that must hold every value from 0 up to n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fetch_response_merge_output_buffer.sv
// In-order buffer of merged instructions waiting for decode. A depth of one collapses to a
// single register; larger depths use a circular buffer. Clear empties it in one cycle.
module fetch_output_buffer
    import fetch_response_merge_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW   = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  fetch_instr_t  push_data,
    input  logic          pop,
    output fetch_instr_t  head,
    output logic          valid,
    output logic [CW-1:0] count
);

    if (DEPTH == 1) begin : g_reg
        fetch_instr_t slot;
        logic         full;

        // Occupancy flag; a push while full (with the pop) keeps it set.
        always_ff @(posedge clk) begin
            if (rst || clear) full <= 1'b0;
            else if (push)    full <= 1'b1;
            else if (pop)     full <= 1'b0;
        end

        // Payload is not reset; it is only observed while full is set.
        always_ff @(posedge clk) begin
            if (push && !clear) slot <= push_data;
        end

        assign head  = slot;
        assign valid = full;
        assign count = CW'(full);
    end else begin : g_ring
        localparam int PW = $clog2(DEPTH);

        fetch_instr_t  mem [DEPTH];
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [CW-1:0] cnt;
        logic          pop_eff;

        function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
            return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
        endfunction

        assign pop_eff = pop && (cnt != '0);

        // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
        always_ff @(posedge clk) begin
            if (rst || clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push)    wr_ptr <= bump(wr_ptr);
                if (pop_eff) rd_ptr <= bump(rd_ptr);
                if (push && !pop_eff)      cnt <= cnt + CW'(1);
                else if (!push && pop_eff) cnt <= cnt - CW'(1);
            end
        end

        // Storage writes; when full the write slot equals the slot being popped.
        always_ff @(posedge clk) begin
            if (push && !clear) mem[wr_ptr] <= push_data;
        end

        assign head  = mem[rd_ptr];
        assign valid = (cnt != '0);
        assign count = cnt;
    end

endmodule

// File: rtl/fetch_response_merge.sv
// Pairs each memory response with the attributes FIFO head and queues the merged instruction
// for decode. Memory responses cannot stall, so new requests are gated by a credit count that
// covers both in-flight requests and buffered results. After a flush, responses to requests
// already in flight are counted down and dropped.
module fetch_response_merge
    import fetch_response_merge_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int XLEN            = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_issue,
    output logic            req_allowed,
    input  logic            attr_valid,
    input  fetch_attr_t     attr_data,
    output logic            attr_pop,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic            out_pred_taken,
    output logic            out_fault
);

    localparam int            CW    = cnt_width(MAX_OUTSTANDING);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW:0]   LIMIT = (CW + 1)'(MAX_OUTSTANDING);

    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] discard;
    logic [CW-1:0] buffered;
    logic          push;
    logic          pop;
    logic          buf_valid;
    fetch_instr_t  merged;
    fetch_instr_t  head;

    // Requests in flight after this cycle; issue and response together cancel out.
    always_comb begin
        outstanding_next = outstanding;
        case ({req_issue, resp_valid})
            2'b10:   outstanding_next = outstanding + ONE;
            2'b01:   outstanding_next = outstanding - ONE;
            default: outstanding_next = outstanding;
        endcase
    end

    // Credits come from registered state only, so decode's ready never reaches fetch.
    assign req_allowed = ({1'b0, outstanding} + {1'b0, buffered}) < LIMIT;

    // Every response consumes its attributes entry, whether kept or dropped.
    assign attr_pop = resp_valid;
    assign push     = resp_valid && (discard == '0) && !flush;
    assign pop      = buf_valid && out_ready;
    assign merged   = fetch_instr_t'({attr_data, resp_data[XLEN-1:0]});

    // In-flight and to-be-dropped counters. A flush reloads discard with everything still in
    // flight (including a request issued in the flush cycle), replacing any previous value.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (flush)
                discard <= outstanding_next;
            else if (resp_valid && (discard != '0))
                discard <= discard - ONE;
        end
    end

    fetch_output_buffer #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_obuf (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .push     (push),
        .push_data(merged),
        .pop      (pop),
        .head     (head),
        .valid    (buf_valid),
        .count    (buffered)
    );

    assign out_valid      = buf_valid;
    assign out_pc         = head.attr.pc;
    assign out_instr      = head.instr;
    assign out_pred_taken = head.attr.predicted_taken;
    assign out_fault      = head.attr.fault;

    a_resp_has_attr: assert property (@(posedge clk) disable iff (rst) resp_valid |-> attr_valid);
    a_issue_legal:   assert property (@(posedge clk) disable iff (rst) req_issue |-> req_allowed);
    a_resp_expected: assert property (@(posedge clk) disable iff (rst) resp_valid |-> (outstanding != '0));

endmodule
